adder_tree_sched: RTL and testbench

//  Collects a stream of unsigned operands into groups of up to 9 and issues each group
//  to the shared 9-input unsigned adder tree (sum width WIDTH+4).

---
 rtl/adder_tree_sched.sv | 107 ++++++++++
 tb/tb_adder_tree_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder_tree_sched: groups up to 9 operands for a shared 9-input adder tree |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module adder_tree_sched #(
  parameter int WIDTH   = 23,
  parameter int ADD_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic [9*WIDTH-1:0]   at_operands,
  input  logic [WIDTH+3:0]     at_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH+3:0]     out_sum,
  output logic [3:0]           out_cnt
);

  localparam logic [3:0] C_LAT = 4'(ADD_LAT);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_slot [9];
  logic [3:0]           r_cnt;
  logic [3:0]           r_wcnt;
  logic [WIDTH+3:0]     r_sum;
  logic [3:0]           r_ocnt;
  logic                 w_accept;
  logic                 w_close;

  assign w_accept  = in_valid && (r_state == S_FILL);
  assign w_close   = (r_cnt == 4'd8) || in_last;
  assign in_ready  = (r_state == S_FILL);
  assign out_valid = (r_state == S_HOLD);
  assign out_sum   = r_sum;
  assign out_cnt   = r_ocnt;

  // Unfilled slots stay at zero so a short group sums correctly in the tree.
  for (genvar k = 0; k < 9; k++) begin : g_ops
    assign at_operands[k*WIDTH +: WIDTH] = r_slot[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FILL;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FILL:  if (w_accept && w_close) w_next = S_WAIT;
      S_WAIT:  if (r_wcnt == 4'd0) w_next = S_HOLD;
      S_HOLD:  if (out_ready) w_next = S_FILL;
      default: w_next = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) r_slot[k] <= '0;
      r_cnt  <= 4'd0;
      r_wcnt <= 4'd0;
      r_sum  <= '0;
      r_ocnt <= 4'd0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            for (int k = 0; k < 9; k++) begin
              if (r_cnt == 4'(k)) r_slot[k] <= in_data;
            end
            r_cnt <= r_cnt + 4'd1;
            if (w_close) r_wcnt <= C_LAT;
          end
        end
        S_WAIT: begin
          if (r_wcnt != 4'd0) begin
            r_wcnt <= r_wcnt - 4'd1;
          end else begin
            r_sum  <= at_sum;
            r_ocnt <= r_cnt;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            for (int k = 0; k < 9; k++) r_slot[k] <= '0;
            r_cnt <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_adder_tree_sched: directed vectors against ADD_LAT=0 and ADD_LAT=2     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_adder_tree_sched;

  localparam int W = 23;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [W-1:0]    in_data = '0;
  logic            in_last = 1'b0;
  logic            out_ready = 1'b1;
  logic            sel = 1'b0;
  logic            force_zero = 1'b0;

  logic            rdy0, rdy2, ov0, ov2;
  logic [9*W-1:0]  ops0, ops2;
  logic [W+3:0]    ats0, ats2, os0, os2, p1, p2;
  logic [3:0]      oc0, oc2;

  logic            rdy_m, ov_m;
  logic [9*W-1:0]  ops_m;
  logic [W+3:0]    os_m;
  logic [3:0]      oc_m;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [W+3:0] tree(input logic [9*W-1:0] ops);
    logic [W+3:0] s = '0;
    for (int k = 0; k < 9; k++) s = s + (W+4)'(ops[k*W +: W]);
    return s;
  endfunction

  assign ats0 = tree(ops0);
  always_ff @(posedge clk) begin
    p1 <= tree(ops2);
    p2 <= p1;
  end
  assign ats2 = force_zero ? '0 : p2;

  adder_tree_sched #(.WIDTH(W), .ADD_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(rdy0),
    .in_data(in_data), .in_last(in_last), .at_operands(ops0), .at_sum(ats0),
    .out_valid(ov0), .out_ready(out_ready), .out_sum(os0), .out_cnt(oc0));

  adder_tree_sched #(.WIDTH(W), .ADD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(rdy2),
    .in_data(in_data), .in_last(in_last), .at_operands(ops2), .at_sum(ats2),
    .out_valid(ov2), .out_ready(out_ready), .out_sum(os2), .out_cnt(oc2));

  assign rdy_m = sel ? rdy2 : rdy0;
  assign ov_m  = sel ? ov2  : ov0;
  assign ops_m = sel ? ops2 : ops0;
  assign os_m  = sel ? os2  : os0;
  assign oc_m  = sel ? oc2  : oc0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Returns #1 after the edge at which the beat was taken.
  task automatic send_beat(input logic [W-1:0] d, input logic last);
    int guard = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!rdy_m && guard < 50) begin step(); guard++; end
    if (guard >= 50) check("in_ready_timeout", 0, 1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!ov_m && lat < 40) begin step(); lat++; end
    if (lat >= 40) check("out_valid_timeout", 0, 1);
  endtask

  typedef struct {
    int                 n;
    logic               use_last;
    logic [8:0][W-1:0]  d;
    logic [W+3:0]       exp_sum;
    logic [3:0]         exp_cnt;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int lat;
    logic [9*W-1:0] exp_ops;

    for (int k = 0; k < 9; k++) begin
      tbl[0].d[k] = W'(k + 1);
      tbl[1].d[k] = 23'h7FFFFF;
      tbl[2].d[k] = (k < 4) ? W'(10 * (k + 1)) : '0;
      tbl[3].d[k] = (k == 0) ? W'(5) : '0;
      tbl[4].d[k] = W'(100);
    end
    tbl[0].n = 9; tbl[0].use_last = 1'b0; tbl[0].exp_sum = 27'd45;       tbl[0].exp_cnt = 4'd9;
    tbl[1].n = 9; tbl[1].use_last = 1'b0; tbl[1].exp_sum = 27'h47FFFF7;  tbl[1].exp_cnt = 4'd9;
    tbl[2].n = 4; tbl[2].use_last = 1'b1; tbl[2].exp_sum = 27'd100;      tbl[2].exp_cnt = 4'd4;
    tbl[3].n = 1; tbl[3].use_last = 1'b1; tbl[3].exp_sum = 27'd5;        tbl[3].exp_cnt = 4'd1;
    tbl[4].n = 9; tbl[4].use_last = 1'b1; tbl[4].exp_sum = 27'd900;      tbl[4].exp_cnt = 4'd9;

    #12;
    check("rst_in_ready", rdy_m, 1);
    check("rst_out_valid", ov_m, 0);
    check("rst_out_sum", os_m, 0);
    check("rst_out_cnt", oc_m, 0);
    check("rst_operands", ops_m, 0);
    rst_n = 1'b1;
    step();

    // Table: ADD_LAT=0, out_ready held high.
    for (int v = 0; v < 5; v++) begin
      exp_ops = '0;
      for (int k = 0; k < tbl[v].n; k++) begin
        send_beat(tbl[v].d[k], tbl[v].use_last && (k == tbl[v].n - 1));
        exp_ops[k*W +: W] = tbl[v].d[k];
      end
      check($sformatf("v%0d_wait_operands", v), ops_m, exp_ops);
      wait_result(lat);
      check($sformatf("v%0d_latency", v), lat, 1);
      check($sformatf("v%0d_sum", v), os_m, tbl[v].exp_sum);
      check($sformatf("v%0d_cnt", v), oc_m, tbl[v].exp_cnt);
      step();
      check($sformatf("v%0d_valid_one_cycle", v), ov_m, 0);
    end

    // in_last with in_valid low is ignored.
    send_beat(23'd1, 1'b0);
    in_last = 1'b1; step(); in_last = 1'b0;
    send_beat(23'd2, 1'b1);
    wait_result(lat);
    check("idle_last_sum", os_m, 3);
    check("idle_last_cnt", oc_m, 2);
    step();

    // Output stall with a pending beat; pending beat starts the next group.
    out_ready = 1'b0;
    send_beat(23'd1, 1'b0); send_beat(23'd2, 1'b0); send_beat(23'd3, 1'b1);
    wait_result(lat);
    in_valid = 1'b1; in_data = 23'd7; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stall%0d_sum", i), os_m, 6);
      check($sformatf("stall%0d_ready", i), rdy_m, 0);
      check($sformatf("stall%0d_valid", i), ov_m, 1);
    end
    out_ready = 1'b1;
    step();
    check("release_ready", rdy_m, 1);
    check("release_valid", ov_m, 0);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    check("pending_slot1", ops_m, (9*W)'(7));
    wait_result(lat);
    check("pending_sum", os_m, 7);
    check("pending_cnt", oc_m, 1);
    step();

    // ADD_LAT=2 and at_sum changes after capture.
    sel = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 9; k++) send_beat(W'(k + 1), 1'b0);
    wait_result(lat);
    check("lat2_latency", lat, 3);
    check("lat2_sum", os_m, 45);
    check("lat2_cnt", oc_m, 9);
    force_zero = 1'b1;
    step(); step();
    check("lat2_sum_after_force", os_m, 45);
    check("lat2_valid_held", ov_m, 1);
    out_ready = 1'b1;
    step();
    force_zero = 1'b0; sel = 1'b0;

    // Mid-group reset discards the group.
    for (int k = 0; k < 5; k++) send_beat(W'(k + 1), 1'b0);
    rst_n = 1'b0; #1;
    check("midrst_ready", rdy_m, 1);
    check("midrst_valid", ov_m, 0);
    check("midrst_sum", os_m, 0);
    check("midrst_cnt", oc_m, 0);
    check("midrst_operands", ops_m, 0);
    step(); #3 rst_n = 1'b1;
    step();
    for (int k = 0; k < 9; k++) send_beat(23'd2, 1'b0);
    wait_result(lat);
    check("post_rst_sum", os_m, 18);
    check("post_rst_cnt", oc_m, 9);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
